// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the clk2->clk1 FIFO: upstream stream, synchronised read
// pointer, status flags, Gray write pointer and SRAM write port.
interface fifo_wr_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 6
);
  logic              winc;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W:0]   rptr_sync;
  logic              wfull;
  logic              walmost_full;
  logic [ADDR_W:0]   wcount;
  logic              woverflow;
  logic [ADDR_W:0]   wptr;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  modport master (
    output winc, wdata, rptr_sync,
    input  wfull, walmost_full, wcount, woverflow, wptr,
    input  mem_wen, mem_waddr, mem_wdata
  );

  modport slave (
    input  winc, wdata, rptr_sync,
    output wfull, walmost_full, wcount, woverflow, wptr,
    output mem_wen, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the clk2->clk1 async FIFO: owns the write pointer,
// drives the SRAM write port and derives full/almost-full/occupancy/overflow.
module fifo_wr_ctrl #(
  parameter int WIDTH     = 8,
  parameter int WORDS     = 64,
  parameter int ADDR_W    = 6,
  parameter int AF_MARGIN = 4
) (
  input logic           clk,
  input logic           rst_n,
  fifo_wr_ctrl_if.slave bus
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(WORDS - AF_MARGIN);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wptr_r;
  logic          wfull_r;
  logic          walmost_full_r;
  logic [PW-1:0] wcount_r;
  logic          woverflow_r;

  logic          accept_s;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rbin_sync_s;
  logic [PW-1:0] count_next_s;
  logic [PW-1:0] rptr_full_s;

  // Next pointer, Gray code, occupancy and the Gray pattern meaning "full"
  always_comb begin
    accept_s     = bus.winc & ~wfull_r;
    wbin_next_s  = wbin_r + {{ADDR_W{1'b0}}, accept_s};
    wgray_next_s = bin2gray(wbin_next_s);
    rbin_sync_s  = gray2bin(bus.rptr_sync);
    count_next_s = wbin_next_s - rbin_sync_s;
    // Full when write pointer is one lap ahead: top two Gray bits inverted
    rptr_full_s  = {~bus.rptr_sync[ADDR_W:ADDR_W-1], bus.rptr_sync[ADDR_W-2:0]};
  end

  // Pointer and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_r         <= {PW{1'b0}};
      wptr_r         <= {PW{1'b0}};
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      wcount_r       <= {PW{1'b0}};
      woverflow_r    <= 1'b0;
    end else begin
      wbin_r         <= wbin_next_s;
      wptr_r         <= wgray_next_s;
      wfull_r        <= (wgray_next_s == rptr_full_s);
      walmost_full_r <= (count_next_s >= AF_LEVEL);
      wcount_r       <= count_next_s;
      woverflow_r    <= woverflow_r | (bus.winc & wfull_r);
    end
  end

  assign bus.mem_wen      = accept_s;
  assign bus.mem_waddr    = wbin_r[ADDR_W-1:0];
  assign bus.mem_wdata    = bus.wdata;
  assign bus.wfull        = wfull_r;
  assign bus.walmost_full = walmost_full_r;
  assign bus.wcount       = wcount_r;
  assign bus.woverflow    = woverflow_r;
  assign bus.wptr         = wptr_r;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl: fill, overflow, drain-by-one,
// full pointer wrap and asynchronous reset mid-burst.
module tb_fifo_wr_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   wb;
  int   rb;

  fifo_wr_ctrl_if #(.WIDTH(8), .ADDR_W(6)) bus ();

  fifo_wr_ctrl #(.WIDTH(8), .WORDS(64), .ADDR_W(6), .AF_MARGIN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] gray(input int b);
    logic [6:0] v;
    v = 7'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.winc      = 1'b0;
    bus.wdata     = 8'h00;
    bus.rptr_sync = 7'b0000000;
    tick();
    tick();
    check("rst_wfull", 32'(bus.wfull), 32'd0);
    check("rst_wcount", 32'(bus.wcount), 32'd0);
    check("rst_wptr", 32'(bus.wptr), 32'd0);
    check("rst_wovf", 32'(bus.woverflow), 32'd0);
    check("rst_waf", 32'(bus.walmost_full), 32'd0);
    rst_n = 1'b1;

    // Idle with rptr_sync = 0
    for (int i = 0; i < 5; i++) begin
      #1;
      check("idle_wen", 32'(bus.mem_wen), 32'd0);
      tick();
      check("idle_wfull", 32'(bus.wfull), 32'd0);
      check("idle_wcount", 32'(bus.wcount), 32'd0);
      check("idle_wptr", 32'(bus.wptr), 32'd0);
    end

    // Fill 64 words with no reads
    for (int i = 0; i < 64; i++) begin
      bus.winc  = 1'b1;
      bus.wdata = 8'(i);
      #1;
      check("fill_wen", 32'(bus.mem_wen), 32'd1);
      check("fill_waddr", 32'(bus.mem_waddr), 32'(i));
      check("fill_wdata", 32'(bus.mem_wdata), 32'(i));
      tick();
      check("fill_wcount", 32'(bus.wcount), 32'(i + 1));
      check("fill_waf", 32'(bus.walmost_full), ((i + 1) >= 60) ? 32'd1 : 32'd0);
      check("fill_wfull", 32'(bus.wfull), ((i + 1) == 64) ? 32'd1 : 32'd0);
    end
    check("full_wptr", 32'(bus.wptr), 32'b1100000);

    // Three writes attempted while full are dropped
    for (int i = 0; i < 3; i++) begin
      bus.wdata = 8'hEE;
      #1;
      check("ovf_wen", 32'(bus.mem_wen), 32'd0);
      check("ovf_waddr", 32'(bus.mem_waddr), 32'd0);
      tick();
      check("ovf_flag", 32'(bus.woverflow), 32'd1);
      check("ovf_wcount", 32'(bus.wcount), 32'd64);
      check("ovf_wptr", 32'(bus.wptr), 32'b1100000);
      check("ovf_wfull", 32'(bus.wfull), 32'd1);
    end

    // One read retires a word; full drops the next cycle
    bus.winc      = 1'b0;
    bus.rptr_sync = 7'b0000001;
    tick();
    check("rd1_wfull", 32'(bus.wfull), 32'd0);
    check("rd1_wcount", 32'(bus.wcount), 32'd63);
    check("rd1_waf", 32'(bus.walmost_full), 32'd1);
    bus.winc  = 1'b1;
    bus.wdata = 8'hA5;
    #1;
    check("rd1_wen", 32'(bus.mem_wen), 32'd1);
    check("rd1_waddr", 32'(bus.mem_waddr), 32'd0);
    check("rd1_wdata", 32'(bus.mem_wdata), 32'hA5);
    tick();
    check("rd1_refull", 32'(bus.wfull), 32'd1);
    check("rd1_wcount2", 32'(bus.wcount), 32'd64);
    check("rd1_wptr", 32'(bus.wptr), 32'b1100001);
    check("rd1_ovf_sticky", 32'(bus.woverflow), 32'd1);

    // 128 read/write pairs: write pointer wraps through 127 -> 0
    wb = 65;
    rb = 1;
    for (int i = 0; i < 128; i++) begin
      bus.winc      = 1'b0;
      rb            = (rb + 1) % 128;
      bus.rptr_sync = gray(rb);
      tick();
      check("wrap_wfull_lo", 32'(bus.wfull), 32'd0);
      check("wrap_wcount_lo", 32'(bus.wcount), 32'd63);
      bus.winc  = 1'b1;
      bus.wdata = 8'(i);
      #1;
      check("wrap_wen", 32'(bus.mem_wen), 32'd1);
      check("wrap_waddr", 32'(bus.mem_waddr), 32'(wb % 64));
      tick();
      wb = (wb + 1) % 128;
      check("wrap_wptr", 32'(bus.wptr), 32'(gray(wb)));
      check("wrap_wfull_hi", 32'(bus.wfull), 32'd1);
      if (wb == 0) begin
        check("wrap_wptr_zero", 32'(bus.wptr), 32'b0000000);
      end
    end

    // Drain to 18 words, then two more writes -> occupancy 20
    bus.winc      = 1'b0;
    bus.rptr_sync = gray(47);
    tick();
    check("drain_wcount", 32'(bus.wcount), 32'd18);
    check("drain_wfull", 32'(bus.wfull), 32'd0);
    check("drain_waf", 32'(bus.walmost_full), 32'd0);
    bus.winc = 1'b1;
    tick();
    tick();
    check("burst_wcount", 32'(bus.wcount), 32'd20);

    // Asynchronous reset mid-burst, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wcount", 32'(bus.wcount), 32'd0);
    check("arst_wptr", 32'(bus.wptr), 32'd0);
    check("arst_wfull", 32'(bus.wfull), 32'd0);
    check("arst_wovf", 32'(bus.woverflow), 32'd0);
    check("arst_waf", 32'(bus.walmost_full), 32'd0);
    check("arst_waddr", 32'(bus.mem_waddr), 32'd0);
    bus.winc      = 1'b0;
    bus.rptr_sync = 7'b0000000;
    #1;
    check("arst_wen", 32'(bus.mem_wen), 32'd0);
    tick();
    rst_n     = 1'b1;
    bus.winc  = 1'b1;
    bus.wdata = 8'h3C;
    #1;
    check("resume_wen", 32'(bus.mem_wen), 32'd1);
    check("resume_waddr", 32'(bus.mem_waddr), 32'd0);
    tick();
    check("resume_wcount", 32'(bus.wcount), 32'd1);
    check("resume_wptr", 32'(bus.wptr), 32'b0000001);
    bus.winc = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
